// File: rtl/execute_mc.sv
// Execute stage: single-cycle ALU/multiplier with branch compare, plus a
// multi-cycle restoring divider sequenced by an IDLE/BUSY/DONE FSM.
module execute_mc #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EXE_V,
  input  logic [XLEN-1:0] EXE_ALU1,
  input  logic [XLEN-1:0] EXE_ALU2,
  input  logic [7:0]      EXE_Cst,
  input  logic [31:0]     EXE_IR,
  input  logic [XLEN-1:0] EXE_NPC,
  input  logic [XLEN-1:0] EXE_Target_Address,
  input  logic [XLEN-1:0] EXE_Address,
  input  logic            MEM_STALL,
  output logic            EXE_STALL,
  output logic            V_EXE_FE_BR_STALL,
  output logic [4:0]      EXE_DR,
  output logic            MEM_V,
  output logic [XLEN-1:0] MEM_RES,
  output logic            MEM_PC_MUX,
  output logic [7:0]      MEM_Cst,
  output logic [31:0]     MEM_IR,
  output logic [XLEN-1:0] MEM_NPC,
  output logic [XLEN-1:0] MEM_Target_Address,
  output logic [XLEN-1:0] MEM_Address
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  logic [SHW-1:0]    r_cnt;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvs;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_rem_op;

  logic              w_is_div;
  logic              w_div_start;
  logic              w_signed_div;
  logic              w_div_zero;
  logic              w_ovf;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_alu_res;
  logic [2*XLEN-1:0] w_ma;
  logic [2*XLEN-1:0] w_mb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_exe_res;
  logic              w_cmp;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;
  logic [XLEN-1:0]   w_div_res;

  function automatic logic [XLEN-1:0] f_neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  assign w_is_div     = EXE_Cst[7] & EXE_Cst[2];
  assign w_div_start  = (r_state == S_IDLE) & EXE_V & w_is_div;
  assign w_signed_div = ~EXE_Cst[0];
  assign w_div_zero   = (EXE_ALU2 == '0);
  assign w_ovf        = w_signed_div & (EXE_ALU1 == {1'b1, {(XLEN-1){1'b0}}}) & (&EXE_ALU2);

  assign EXE_STALL         = MEM_STALL | (r_state == S_BUSY) | w_div_start;
  assign V_EXE_FE_BR_STALL = EXE_V & ((EXE_IR[6:2] == 5'b11000) | (EXE_IR[6:2] == 5'b11001) |
                                      (EXE_IR[6:2] == 5'b11011));
  assign EXE_DR            = EXE_IR[11:7];

  assign w_shamt = EXE_ALU2[SHW-1:0];

  always_comb begin
    w_alu_res = EXE_ALU1;
    case (EXE_Cst[3:0])
      4'd0: w_alu_res = EXE_ALU1 + EXE_ALU2;
      4'd1: w_alu_res = EXE_ALU1 - EXE_ALU2;
      4'd2: w_alu_res = EXE_ALU1 << w_shamt;
      4'd3: w_alu_res = {{(XLEN-1){1'b0}}, $signed(EXE_ALU1) < $signed(EXE_ALU2)};
      4'd4: w_alu_res = {{(XLEN-1){1'b0}}, EXE_ALU1 < EXE_ALU2};
      4'd5: w_alu_res = EXE_ALU1 ^ EXE_ALU2;
      4'd6: w_alu_res = EXE_ALU1 >> w_shamt;
      4'd7: w_alu_res = $signed(EXE_ALU1) >>> w_shamt;
      4'd8: w_alu_res = EXE_ALU1 | EXE_ALU2;
      4'd9: w_alu_res = EXE_ALU1 & EXE_ALU2;
      default: w_alu_res = EXE_ALU1;
    endcase
  end

  // Operands extended to 2*XLEN per signedness; the low 2*XLEN product bits are exact.
  assign w_ma   = {{XLEN{(EXE_Cst[1:0] != 2'b11) & EXE_ALU1[XLEN-1]}}, EXE_ALU1};
  assign w_mb   = {{XLEN{~EXE_Cst[1] & EXE_ALU2[XLEN-1]}}, EXE_ALU2};
  assign w_prod = w_ma * w_mb;

  assign w_exe_res = !EXE_Cst[7]            ? w_alu_res :
                     (EXE_Cst[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_comb begin
    w_cmp = 1'b0;
    case (EXE_Cst[6:4])
      3'd0: w_cmp = (EXE_ALU1 == EXE_ALU2);
      3'd1: w_cmp = (EXE_ALU1 != EXE_ALU2);
      3'd2: w_cmp = ($signed(EXE_ALU1) <  $signed(EXE_ALU2));
      3'd3: w_cmp = ($signed(EXE_ALU1) >= $signed(EXE_ALU2));
      3'd4: w_cmp = (EXE_ALU1 <  EXE_ALU2);
      3'd5: w_cmp = (EXE_ALU1 >= EXE_ALU2);
      default: w_cmp = 1'b0;
    endcase
  end

  assign w_mag_a   = f_neg_if(w_signed_div & EXE_ALU1[XLEN-1], EXE_ALU1);
  assign w_mag_b   = f_neg_if(w_signed_div & EXE_ALU2[XLEN-1], EXE_ALU2);
  assign w_trial   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_trial - {1'b0, r_dvs};
  assign w_div_res = r_rem_op ? f_neg_if(r_neg_r, r_rem) : f_neg_if(r_neg_q, r_quo);

  // Divider datapath: special cases preload the final result with no sign fix-up.
  always_ff @(posedge CLK) begin
    if (w_div_start) begin
      r_rem_op <= EXE_Cst[1];
      r_dvs    <= w_mag_b;
      if (w_div_zero) begin
        r_quo   <= '1;
        r_rem   <= EXE_ALU1;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_ovf) begin
        r_quo   <= EXE_ALU1;
        r_rem   <= '0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_quo   <= w_mag_a;
        r_rem   <= '0;
        r_neg_q <= w_signed_div & (EXE_ALU1[XLEN-1] ^ EXE_ALU2[XLEN-1]);
        r_neg_r <= w_signed_div & EXE_ALU1[XLEN-1];
      end
    end else if (r_state == S_BUSY) begin
      if (!w_diff[XLEN]) begin
        r_rem <= w_diff[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_trial[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state            <= S_IDLE;
      r_cnt              <= '0;
      MEM_V              <= 1'b0;
      MEM_RES            <= '0;
      MEM_PC_MUX         <= 1'b0;
      MEM_Cst            <= '0;
      MEM_IR             <= '0;
      MEM_NPC            <= '0;
      MEM_Target_Address <= '0;
      MEM_Address        <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_div_start) begin
          r_state <= (w_div_zero | w_ovf) ? S_DONE : S_BUSY;
          r_cnt   <= '0;
        end
        S_BUSY: if (r_cnt == SHW'(XLEN-1)) begin
          r_state <= S_DONE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + SHW'(1);
        end
        S_DONE: if (!MEM_STALL) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // EXE_* are held by upstream until DONE releases the stall, so they still describe the divide here.
      if (!MEM_STALL) begin
        if ((r_state == S_DONE) || ((r_state == S_IDLE) && !w_div_start)) begin
          MEM_V              <= (r_state == S_DONE) ? 1'b1 : EXE_V;
          MEM_RES            <= (r_state == S_DONE) ? w_div_res : w_exe_res;
          MEM_PC_MUX         <= w_cmp;
          MEM_Cst            <= EXE_Cst;
          MEM_IR             <= EXE_IR;
          MEM_NPC            <= EXE_NPC;
          MEM_Target_Address <= EXE_Target_Address;
          MEM_Address        <= EXE_Address;
        end else begin
          MEM_V <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc: directed vector table, multi-cycle divide/stall/reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_execute_mc;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        EXE_V;
  logic [63:0] EXE_ALU1, EXE_ALU2, EXE_NPC, EXE_Target_Address, EXE_Address;
  logic [7:0]  EXE_Cst;
  logic [31:0] EXE_IR;
  logic        MEM_STALL;
  logic        EXE_STALL, V_EXE_FE_BR_STALL, MEM_V, MEM_PC_MUX;
  logic [4:0]  EXE_DR;
  logic [63:0] MEM_RES, MEM_NPC, MEM_Target_Address, MEM_Address;
  logic [7:0]  MEM_Cst;
  logic [31:0] MEM_IR;

  logic        d_v;
  logic [31:0] d_a1, d_a2, d_npc, d_tgt, d_addr, d_ir;
  logic [7:0]  d_cst;
  logic        s_stall, s_brst, s_v, s_pcmux;
  logic [4:0]  s_dr;
  logic [31:0] s_res, s_npc, s_tgt, s_addr, s_ir;
  logic [7:0]  s_cst;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] last_res;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  always #5 CLK = ~CLK;

  execute_mc #(.XLEN(64)) dut (
    .CLK(CLK), .RESET(RESET), .EXE_V(EXE_V), .EXE_ALU1(EXE_ALU1), .EXE_ALU2(EXE_ALU2),
    .EXE_Cst(EXE_Cst), .EXE_IR(EXE_IR), .EXE_NPC(EXE_NPC), .EXE_Target_Address(EXE_Target_Address),
    .EXE_Address(EXE_Address), .MEM_STALL(MEM_STALL), .EXE_STALL(EXE_STALL),
    .V_EXE_FE_BR_STALL(V_EXE_FE_BR_STALL), .EXE_DR(EXE_DR), .MEM_V(MEM_V), .MEM_RES(MEM_RES),
    .MEM_PC_MUX(MEM_PC_MUX), .MEM_Cst(MEM_Cst), .MEM_IR(MEM_IR), .MEM_NPC(MEM_NPC),
    .MEM_Target_Address(MEM_Target_Address), .MEM_Address(MEM_Address)
  );

  execute_mc #(.XLEN(32)) dut32 (
    .CLK(CLK), .RESET(RESET), .EXE_V(d_v), .EXE_ALU1(d_a1), .EXE_ALU2(d_a2),
    .EXE_Cst(d_cst), .EXE_IR(d_ir), .EXE_NPC(d_npc), .EXE_Target_Address(d_tgt),
    .EXE_Address(d_addr), .MEM_STALL(1'b0), .EXE_STALL(s_stall),
    .V_EXE_FE_BR_STALL(s_brst), .EXE_DR(s_dr), .MEM_V(s_v), .MEM_RES(s_res),
    .MEM_PC_MUX(s_pcmux), .MEM_Cst(s_cst), .MEM_IR(s_ir), .MEM_NPC(s_npc),
    .MEM_Target_Address(s_tgt), .MEM_Address(s_addr)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Reference model: results straight from the instruction semantics.
  function automatic logic [63:0] model_res(input logic [7:0] cst, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    int sh;
    logic signed [127:0] pa, pb, pbu;
    logic [127:0] prod;
    sa = a; sb = b; sh = int'(b[5:0]);
    pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; pbu = {64'd0, b};
    if (!cst[7]) begin
      case (cst[3:0])
        4'd0: return a + b;
        4'd1: return a - b;
        4'd2: return a << sh;
        4'd3: return (sa < sb) ? 64'd1 : 64'd0;
        4'd4: return (a < b) ? 64'd1 : 64'd0;
        4'd5: return a ^ b;
        4'd6: return a >> sh;
        4'd7: return sa >>> sh;
        4'd8: return a | b;
        4'd9: return a & b;
        default: return a;
      endcase
    end
    case (cst[2:0])
      3'd0: return a * b;
      3'd1: begin prod = pa * pb;  return prod[127:64]; end
      3'd2: begin prod = pa * pbu; return prod[127:64]; end
      3'd3: begin prod = {64'd0, a} * {64'd0, b}; return prod[127:64]; end
      default: begin
        if (b == 64'd0) return cst[1] ? a : '1;
        if (!cst[0] && a == MIN64 && sb == -64'sd1) return cst[1] ? 64'd0 : a;
        case (cst[1:0])
          2'd0: return sa / sb;
          2'd1: return a / b;
          2'd2: return sa % sb;
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic logic model_br(input logic [7:0] cst, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    sa = a; sb = b;
    case (cst[6:4])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa < sb;
      3'd3: return sa >= sb;
      3'd4: return a < b;
      3'd5: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_brstall(input logic v, input logic [31:0] ir);
    return v && (ir[6:2] == 5'b11000 || ir[6:2] == 5'b11001 || ir[6:2] == 5'b11011);
  endfunction

  task automatic drive(input logic [7:0] cst, input logic [63:0] a, input logic [63:0] b,
                       input logic [31:0] ir, input logic [63:0] sb);
    EXE_V = 1'b1; EXE_Cst = cst; EXE_ALU1 = a; EXE_ALU2 = b; EXE_IR = ir;
    EXE_NPC = sb; EXE_Target_Address = ~sb; EXE_Address = sb ^ 64'h5A5A;
  endtask

  task automatic check_mem(input string nm, input logic [7:0] cst, input logic [63:0] a,
                           input logic [63:0] b, input logic [31:0] ir, input logic [63:0] sb,
                           input logic [63:0] exp_res);
    check({nm, " MEM_RES"}, MEM_RES, exp_res);
    check({nm, " MEM_PC_MUX"}, 64'(MEM_PC_MUX), 64'(model_br(cst, a, b)));
    check({nm, " MEM_V"}, 64'(MEM_V), 64'd1);
    check({nm, " MEM_IR"}, 64'(MEM_IR), 64'(ir));
    check({nm, " MEM_NPC"}, MEM_NPC, sb);
    check({nm, " MEM_TGT"}, MEM_Target_Address, ~sb);
    check({nm, " MEM_ADDR"}, MEM_Address, sb ^ 64'h5A5A);
    check({nm, " MEM_Cst"}, 64'(MEM_Cst), 64'(cst));
    last_res = exp_res;
  endtask

  task automatic do_op(input string nm, input logic [7:0] cst, input logic [63:0] a, input logic [63:0] b,
                       input logic [31:0] ir, input logic [63:0] sb, input logic [63:0] exp_res,
                       input logic exp_br);
    drive(cst, a, b, ir, sb);
    #1;
    check({nm, " EXE_STALL"}, 64'(EXE_STALL), 64'd0);
    check({nm, " EXE_DR"}, 64'(EXE_DR), 64'(ir[11:7]));
    check({nm, " BR_STALL"}, 64'(V_EXE_FE_BR_STALL), 64'(model_brstall(1'b1, ir)));
    @(posedge CLK); #1;
    check({nm, " br"}, 64'(MEM_PC_MUX), 64'(exp_br));
    check_mem(nm, cst, a, b, ir, sb, exp_res);
  endtask

  task automatic do_div(input string nm, input logic [7:0] cst, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_stall);
    int n;
    logic v_bad;
    logic [31:0] ir;
    logic [63:0] sb;
    n = 0; v_bad = 1'b0;
    ir = 32'h0000_0533; sb = {$urandom, $urandom};
    drive(cst, a, b, ir, sb);
    #1;
    while (EXE_STALL && n < 200) begin
      n++;
      @(posedge CLK); #1;
      if (MEM_V) v_bad = 1'b1;
    end
    check({nm, " stall cycles"}, 64'(n), 64'(exp_stall));
    check({nm, " MEM_V low while busy"}, 64'(v_bad), 64'd0);
    @(posedge CLK); #1;
    check_mem(nm, cst, a, b, ir, sb, exp_res);
    EXE_V = 1'b0;
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [7:0]  cst;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        br;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] ir;
    logic        exp;
  } brv_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    brv_t brv[5];
    vecs[0]  = '{8'h00, 64'd5, -64'd3, 64'd2, 1'b0};
    vecs[1]  = '{8'h01, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[2]  = '{8'h02, 64'd1, 64'h41, 64'd2, 1'b0};
    vecs[3]  = '{8'h23, '1, 64'd1, 64'd1, 1'b1};
    vecs[4]  = '{8'h44, '1, 64'd1, 64'd0, 1'b0};
    vecs[5]  = '{8'h15, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b1};
    vecs[6]  = '{8'h56, MIN64, 64'd63, 64'd1, 1'b1};
    vecs[7]  = '{8'h37, MIN64, 64'd4, 64'hF800_0000_0000_0000, 1'b0};
    vecs[8]  = '{8'h68, 64'h0F, 64'hF0, 64'hFF, 1'b0};
    vecs[9]  = '{8'h79, 64'hFF, 64'h3C, 64'h3C, 1'b0};
    vecs[10] = '{8'h0A, 64'h1234, 64'h1234, 64'h1234, 1'b1};
    vecs[11] = '{8'h0F, 64'd7, 64'd0, 64'd7, 1'b0};
    vecs[12] = '{8'h80, 64'd3, -64'd2, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0};
    vecs[13] = '{8'h81, '1, '1, 64'd0, 1'b1};
    vecs[14] = '{8'h82, '1, '1, '1, 1'b1};
    vecs[15] = '{8'h83, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    brv[0] = '{1'b1, 32'h0000_0063, 1'b1};
    brv[1] = '{1'b1, 32'h0000_0067, 1'b1};
    brv[2] = '{1'b1, 32'h0000_006F, 1'b1};
    brv[3] = '{1'b1, 32'h0000_0033, 1'b0};
    brv[4] = '{1'b0, 32'h0000_0063, 1'b0};

    RESET = 1'b1; MEM_STALL = 1'b1;
    drive(8'h00, 64'd9, 64'd9, 32'hFFFF_FFFF, 64'h1234);
    d_v = 1'b1; d_cst = 8'h00; d_a1 = 32'd1; d_a2 = 32'd2; d_ir = 32'h33;
    d_npc = 32'd4; d_tgt = 32'd8; d_addr = 32'd12;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0; MEM_STALL = 1'b0; EXE_V = 1'b0; d_v = 1'b0;
    #1;
    check("reset MEM_V", 64'(MEM_V), 64'd0);
    check("reset MEM_RES", MEM_RES, 64'd0);
    check("reset MEM_PC_MUX", 64'(MEM_PC_MUX), 64'd0);
    check("reset MEM_IR", 64'(MEM_IR), 64'd0);
    check("reset MEM_NPC", MEM_NPC, 64'd0);
    check("reset EXE_STALL", 64'(EXE_STALL), 64'd0);
    check("reset MEM_V 32", 64'(s_v), 64'd0);

    EXE_Cst = 8'h00;
    foreach (brv[i]) begin
      EXE_V = brv[i].v; EXE_IR = brv[i].ir | 32'h0000_0A80;
      #1;
      check($sformatf("br_stall[%0d]", i), 64'(V_EXE_FE_BR_STALL), 64'(brv[i].exp));
      check($sformatf("exe_dr[%0d]", i), 64'(EXE_DR), 64'd21);
    end
    EXE_V = 1'b0;
    @(posedge CLK); #1;

    foreach (vecs[i])
      do_op($sformatf("vec[%0d]", i), vecs[i].cst, vecs[i].a, vecs[i].b,
            32'h0000_0033 | (32'(i) << 7), 64'(i * 4), vecs[i].res, vecs[i].br);
    EXE_V = 1'b0;

    do_div("DIV -20/3", 8'h84, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    do_div("REM -20/3", 8'h86, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    do_div("DIVU x/0", 8'h85, 64'd12345, 64'd0, '1, 1);
    do_div("REMU 7/0", 8'h87, 64'd7, 64'd0, 64'd7, 1);
    do_div("DIV ovf", 8'h84, MIN64, '1, MIN64, 1);
    do_div("REM ovf", 8'h86, MIN64, '1, 64'd0, 1);

    // Downstream hold across the whole divide and three cycles of DONE.
    begin
      logic [63:0] held;
      drive(8'h85, 64'd100, 64'd7, 32'h0000_00B3, 64'h77);
      @(posedge CLK); #1;
      MEM_STALL = 1'b1;
      held = last_res;
      check("hold MEM_V after accept", 64'(MEM_V), 64'd0);
      repeat (64) @(posedge CLK);
      for (int k = 0; k < 3; k++) begin
        @(posedge CLK); #1;
        check($sformatf("hold MEM_V[%0d]", k), 64'(MEM_V), 64'd0);
        check($sformatf("hold MEM_RES[%0d]", k), MEM_RES, held);
      end
      MEM_STALL = 1'b0;
      #1;
      check("hold release EXE_STALL", 64'(EXE_STALL), 64'd0);
      @(posedge CLK); #1;
      check_mem("hold result", 8'h85, 64'd100, 64'd7, 32'h0000_00B3, 64'h77, 64'd14);
      EXE_V = 1'b0;
    end

    // Reset during divide iteration 10.
    drive(8'h84, -64'd20, 64'd3, 32'h0000_0033, 64'h99);
    @(posedge CLK);
    repeat (10) @(posedge CLK);
    #1;
    RESET = 1'b1; EXE_V = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("abort MEM_V", 64'(MEM_V), 64'd0);
    check("abort EXE_STALL", 64'(EXE_STALL), 64'd0);
    check("abort MEM_RES", MEM_RES, 64'd0);
    do_op("post-abort ADD", 8'h00, 64'd40, 64'd2, 32'h0000_00B3, 64'h10, 64'd42, 1'b0);
    EXE_V = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [7:0] cst;
      logic [63:0] a, b;
      int kind;
      kind = $urandom_range(0, 9);
      a = rand_opnd(); b = rand_opnd();
      if (kind < 5)      cst = {1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      else if (kind < 8) cst = {1'b1, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom_range(0, 3))};
      else               cst = {1'b1, 3'($urandom_range(0, 7)), 2'b01, 2'($urandom_range(0, 3))};
      if (kind >= 8)
        do_div($sformatf("rnd[%0d]", i), cst, a, b, model_res(cst, a, b),
               (b == 64'd0 || (!cst[0] && a == MIN64 && b == '1)) ? 1 : 65);
      else
        do_op($sformatf("rnd[%0d]", i), cst, a, b, $urandom, {$urandom, $urandom},
              model_res(cst, a, b), model_br(cst, a, b));
    end
    EXE_V = 1'b0;

    d_v = 1'b1; d_cst = 8'h07; d_a1 = 32'h8000_0000; d_a2 = 32'h25;
    @(posedge CLK); #1;
    check("x32 SRA", 64'(s_res), 64'h0000_0000_FC00_0000);
    check("x32 SRA MEM_V", 64'(s_v), 64'd1);
    d_cst = 8'h40; d_a1 = 32'd1; d_a2 = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    check("x32 BLTU taken", 64'(s_pcmux), 64'd1);
    d_cst = 8'h50;
    @(posedge CLK); #1;
    check("x32 BGEU not taken", 64'(s_pcmux), 64'd0);
    d_v = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 EXE_V  input  1  instruction valid.
REQ-006 EXE_ALU1, EXE_ALU2  input  XLEN  operands.
REQ-007 EXE_Cst  input  8  control: [3:0] ALU op, [6:4] branch compare, [7] M-extension select.
REQ-008 EXE_IR  input  32  instruction word.
REQ-009 EXE_NPC, EXE_Target_Address, EXE_Address  input  XLEN  sideband, passed through.
REQ-010 MEM_STALL  input  1  downstream hold.
REQ-011 EXE_STALL  output  1  upstream must hold all EXE_* inputs while high.
REQ-012 V_EXE_FE_BR_STALL  output  1  combinational, EXE_V and EXE_IR[6:2] in {11000, 11001, 11011}.
REQ-013 EXE_DR  output  5  combinational, EXE_IR[11:7].
REQ-014 MEM_V  output  1  result valid.
REQ-015 MEM_RES  output  XLEN  result; MEM_PC_MUX  output  1  branch taken.
REQ-016 MEM_Cst (8), MEM_IR (32), MEM_NPC, MEM_Target_Address, MEM_Address (XLEN)  output  registered copies of EXE_* counterparts.

Function
REQ-017 ALU ops (Cst[7]=0), Cst[3:0]: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA (arithmetic), 8 OR, 9 AND; 10 and 11-15 pass ALU1.
REQ-018 Shift amount is ALU2[SHW-1:0].
REQ-019 M ops (Cst[7]=1), Cst[2:0]: 0 MUL low XLEN, 1 MULH s*s, 2 MULHSU s*u, 3 MULHU u*u (high XLEN of 2*XLEN product), 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-020 Compare, Cst[6:4]: 0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6-7 MEM_PC_MUX=0; registered with MEM_RES.
REQ-021 Non-divide ops: latency 1; MEM_* load EXE_* on the edge where EXE_STALL=0; MEM_V<=EXE_V.
REQ-022 Divide ops (4-7) use iterative restoring divider, one quotient bit per cycle, on operand magnitudes.
REQ-023 FSM IDLE/BUSY/DONE with XLEN-cycle iteration counter.
REQ-024 IDLE with EXE_V and divide op: latch operands; go to BUSY; zero divisor or signed overflow (ALU1=most-negative, ALU2=-1, DIV/REM) go directly to DONE.
REQ-025 BUSY: XLEN iterations, then DONE; MEM_STALL does not pause iteration.
REQ-026 DONE: apply signs (quotient truncates toward zero; remainder takes dividend sign); if MEM_STALL=0, load MEM_* with MEM_V=1 and go to IDLE; else remain in DONE.
REQ-027 Divide by zero: quotient all-ones (DIV, DIVU); remainder ALU1 (REM, REMU).
REQ-028 Signed overflow: quotient = ALU1; remainder = 0.
REQ-029 EXE_STALL = MEM_STALL or BUSY, or (IDLE and EXE_V and divide op); low in DONE when MEM_STALL=0.
REQ-030 Any state with MEM_STALL=1: all MEM_* registers hold.
REQ-031 MEM_V=0 on every edge where no instruction completes and MEM_STALL=0, including while BUSY.
REQ-032 Divide accepted at edge T: MEM_V=1 visible after T+XLEN+2; special cases after T+2.

Reset
REQ-033 RESET forces IDLE, counter 0, MEM_V=0, MEM_PC_MUX=0, and MEM_RES and all MEM_* registers to 0.
REQ-034 RESET mid-divide aborts the operation with no result; RESET overrides MEM_STALL.

Verification
REQ-035 XLEN=64, ADD 5 + (-3), Cst=0x00 -> next cycle MEM_RES=2, MEM_V=1, EXE_STALL low.
REQ-036 DIV -20/3 -> EXE_STALL high T..T+64, low T+65; MEM_RES=0xFFFFFFFFFFFFFFFA, MEM_V=1 at T+66; REM same operands -> 0xFFFFFFFFFFFFFFFE.
REQ-037 DIVU x/0 -> MEM_RES=0xFFFFFFFFFFFFFFFF at T+2; REMU 7/0 -> 7; DIV 0x8000000000000000/-1 -> 0x8000000000000000; REM same -> 0.
REQ-038 MEM_STALL high 3 cycles while DONE -> MEM_* unchanged, MEM_V held; result loads on the first edge after release.
REQ-039 RESET at BUSY iteration 10 -> next cycle MEM_V=0, state IDLE, EXE_STALL=0 with EXE_V=0.
REQ-040 XLEN=32, SRA 0x80000000 by ALU2=0x25 -> 0xFC000000; BLTU 1<0xFFFFFFFF -> MEM_PC_MUX=1.
